convolution_processor_aip: RTL and testbench



---
 rtl/convolution_processor_aip.sv | 183 ++++++++++++++++++
 tb/tb_convolution_processor_aip.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/convolution_processor_aip.sv
// AIP-bus convolution accelerator: Z = Y * X, with X a fixed 10-tap kernel X[k] = k+1.
// Define CONV_SATURATE_EN for a 64-bit accumulator with Z words saturating at 32'hFFFFFFFF.
module convolution_processor_aip #(
  parameter int          DATAWIDTH   = 32,
  parameter int          MEM_Y_DEPTH = 32,
  parameter int          MEM_Z_DEPTH = 64,
  parameter int          KERNEL_LEN  = 10,
  parameter logic [31:0] IP_ID_VALUE = 32'h1000500B
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic                 en_s,
  input  logic [DATAWIDTH-1:0] data_in,
  output logic [DATAWIDTH-1:0] data_out,
  input  logic                 write,
  input  logic                 read,
  input  logic                 start,
  input  logic [4:0]           conf_dbus,
  output logic                 int_req
);
  localparam int YAW = $clog2(MEM_Y_DEPTH);
  localparam int ZAW = $clog2(MEM_Z_DEPTH);
`ifdef CONV_SATURATE_EN
  localparam int AW = 2 * DATAWIDTH;
`else
  localparam int AW = DATAWIDTH;
`endif

  localparam logic [4:0] CONF_Y  = 5'd0;
  localparam logic [4:0] CONF_YP = 5'd1;
  localparam logic [4:0] CONF_Z  = 5'd2;
  localparam logic [4:0] CONF_ZP = 5'd3;
  localparam logic [4:0] CONF_SZ = 5'd4;
  localparam logic [4:0] CONF_SP = 5'd5;
  localparam logic [4:0] CONF_ST = 5'd30;
  localparam logic [4:0] CONF_ID = 5'd31;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_MAC, S_WR, S_DONE} state_t;

  logic [DATAWIDTH-1:0] mem_y [MEM_Y_DEPTH];
  logic [DATAWIDTH-1:0] mem_z [MEM_Z_DEPTH];

  logic [YAW-1:0]       ptr_y;
  logic [ZAW-1:0]       ptr_z;
  logic [5:0]           size_y, size_ptr;
  logic [7:0]           mask, flags, flags_clr;
  logic                 busy, done_set;
  state_t               state, state_nxt;
  logic [ZAW-1:0]       n, k, k_lo, k_hi, n_last, size_z;
  logic [AW-1:0]        acc, prod;
  logic [DATAWIDTH-1:0] y_word, x_tap, z_word, rd_data, status;
  logic                 host_wr, host_rd, start_ok;

  assign host_wr  = en_s & write;
  assign host_rd  = en_s & read;
  assign start_ok = en_s & start & ~busy;
  assign done_set = en_s && (state == S_DONE);

  // Valid Y indices for output n: max(0, n-(K-1)) .. min(sizeY-1, n)
  assign size_z = ZAW'(size_y);
  assign k_lo   = (n >= ZAW'(KERNEL_LEN-1)) ? n - ZAW'(KERNEL_LEN-1) : '0;
  assign k_hi   = (n < size_z) ? n : size_z - ZAW'(1);
  assign n_last = size_z + ZAW'(KERNEL_LEN-2);

  assign y_word = mem_y[k[YAW-1:0]];
  assign x_tap  = DATAWIDTH'(n - k) + DATAWIDTH'(1);
  assign prod   = AW'(y_word) * AW'(x_tap);

`ifdef CONV_SATURATE_EN
  assign z_word = (|acc[AW-1:DATAWIDTH]) ? '1 : acc[DATAWIDTH-1:0];
`else
  assign z_word = acc[DATAWIDTH-1:0];
`endif

  assign status = {8'h00, mask, 7'h00, busy, flags};

  // ---------------- engine FSM ----------------
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (en_s) begin
      case (state)
        S_IDLE: if (start_ok) state_nxt = S_CLR;
        S_CLR:  state_nxt = (size_y == '0) ? S_DONE : S_MAC;
        S_MAC:  if (k == k_hi) state_nxt = S_WR;
        S_WR:   state_nxt = (n == n_last) ? S_DONE : S_CLR;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      busy <= 1'b0;
      n    <= '0;
      k    <= '0;
      acc  <= '0;
    end else if (en_s) begin
      case (state)
        S_IDLE: if (start_ok) begin
          busy <= 1'b1;
          n    <= '0;
        end
        S_CLR: begin
          acc <= '0;
          k   <= k_lo;
        end
        S_MAC: begin
          acc <= acc + prod;
          k   <= k + ZAW'(1);
        end
        S_WR:   n    <= n + ZAW'(1);
        S_DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // RAMs carry no reset
  always_ff @(posedge clk) begin
    if (host_wr && conf_dbus == CONF_Y) mem_y[ptr_y] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (en_s && state == S_WR) mem_z[n] <= z_word;
  end

  // ---------------- host register file ----------------
  always_comb begin
    rd_data = '0;
    case (conf_dbus)
      CONF_Y:  rd_data = mem_y[ptr_y];
      CONF_YP: rd_data = DATAWIDTH'(ptr_y);
      CONF_Z:  rd_data = mem_z[ptr_z];
      CONF_ZP: rd_data = DATAWIDTH'(ptr_z);
      CONF_SZ: rd_data = DATAWIDTH'(size_y);
      CONF_SP: rd_data = DATAWIDTH'(size_ptr);
      CONF_ST: rd_data = status;
      CONF_ID: rd_data = DATAWIDTH'(IP_ID_VALUE);
      default: rd_data = '0;
    endcase
  end

  assign flags_clr = (host_wr && conf_dbus == CONF_ST) ? data_in[7:0] : 8'h00;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      data_out <= '0;
      ptr_y    <= '0;
      ptr_z    <= '0;
      size_y   <= '0;
      size_ptr <= '0;
      mask     <= '0;
      flags    <= '0;
      int_req  <= 1'b1;
    end else begin
      if (host_rd) begin
        data_out <= rd_data;
        if (conf_dbus == CONF_Z) ptr_z <= ptr_z + ZAW'(1);
      end
      if (host_wr) begin
        case (conf_dbus)
          CONF_Y:  ptr_y    <= ptr_y + YAW'(1);
          CONF_YP: ptr_y    <= data_in[YAW-1:0];
          CONF_ZP: ptr_z    <= data_in[ZAW-1:0];
          CONF_SZ: size_y   <= (data_in[5:0] > 6'(MEM_Y_DEPTH)) ? 6'(MEM_Y_DEPTH) : data_in[5:0];
          CONF_SP: size_ptr <= data_in[5:0];
          CONF_ST: mask     <= data_in[23:16];
          default: ;
        endcase
      end
      // a done event wins over a simultaneous host clear
      flags   <= (flags & ~flags_clr) | {7'h00, done_set};
      int_req <= ~|(flags & mask);
    end
  end

endmodule

// File: tb/tb_convolution_processor_aip.sv
// Randomized bench for convolution_processor_aip against a plain-arithmetic convolution model.
module tb_convolution_processor_aip;
  logic        clk = 1'b0;
  logic        rst_a, en_s, write, read, start;
  logic [31:0] data_in, data_out;
  logic [4:0]  conf_dbus;
  logic        int_req;

  int total = 0;
  int bad   = 0;

  logic [31:0] ym [32];
  logic [31:0] zm [64];
  logic [31:0] rd;
  logic [31:0] exp5 [14] = '{32'd1, 32'd4, 32'd10, 32'd20, 32'd35, 32'd50, 32'd65,
                             32'd80, 32'd95, 32'd110, 32'd114, 32'd106, 32'd85, 32'd50};

  convolution_processor_aip dut (
    .clk(clk), .rst_a(rst_a), .en_s(en_s), .data_in(data_in), .data_out(data_out),
    .write(write), .read(read), .start(start), .conf_dbus(conf_dbus), .int_req(int_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [4:0] c, input logic [31:0] d);
    @(negedge clk);
    conf_dbus = c; data_in = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] c, output logic [31:0] d);
    @(negedge clk);
    conf_dbus = c; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = data_out;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_irq(input string tag);
    for (int i = 0; i < 3000 && int_req; i++) @(negedge clk);
    chk(tag, {31'b0, int_req}, 32'd0);
  endtask

  // Full 1-D convolution straight from the definition, wrapping mod 2^32
  task automatic model(input int sz);
    for (int n = 0; n < 64; n++) begin
      zm[n] = 32'd0;
      for (int k = 0; k < sz; k++)
        if (n - k >= 0 && n - k < 10) zm[n] = zm[n] + ym[k] * 32'(n - k + 1);
    end
  endtask

  // Fill all of Y starting at a wrapping offset
  task automatic load_y(input int off, input bit full);
    logic [31:0] v;
    bus_wr(5'd1, 32'(off));
    for (int i = 0; i < 32; i++) begin
      v = full ? $urandom : $urandom_range(0, 1000);
      ym[(off + i) % 32] = v;
      bus_wr(5'd0, v);
    end
  endtask

  task automatic check_z(input int sz, input string tag);
    model(sz);
    bus_wr(5'd3, 32'd0);
    for (int n = 0; n < sz + 9 && sz > 0; n++) begin
      bus_rd(5'd2, rd);
      chk($sformatf("%s_z%0d", tag, n), rd, zm[n]);
    end
    bus_rd(5'd3, rd);
    chk({tag, "_zptr"}, rd, (sz == 0) ? 32'd0 : 32'(sz + 9));
  endtask

  task automatic run_check(input int sz, input string tag);
    bus_wr(5'd4, 32'(sz));
    bus_wr(5'd30, 32'h0001_0001);
    pulse_start();
    wait_irq({tag, "_irq"});
    bus_rd(5'd30, rd);
    chk({tag, "_status"}, rd, 32'h0001_0001);
    check_z(sz, tag);
    bus_wr(5'd30, 32'h0001_0001);
  endtask

  initial begin
    int sz;
    rst_a = 1'b0; en_s = 1'b1; write = 1'b0; read = 1'b0; start = 1'b0;
    conf_dbus = 5'd0; data_in = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_int_req", {31'b0, int_req}, 32'd1);
    chk("rst_data_out", data_out, 32'd0);
    rst_a = 1'b1;
    bus_rd(5'd31, rd); chk("ip_id", rd, 32'h1000_500B);
    bus_rd(5'd30, rd); chk("status_rst", rd, 32'd0);
    bus_rd(5'd7, rd);  chk("unmapped", rd, 32'd0);

    // directed Y = {1..5}
    bus_wr(5'd30, 32'h0001_0000);
    bus_wr(5'd1, 32'd0);
    for (int i = 0; i < 5; i++) bus_wr(5'd0, 32'(i + 1));
    bus_wr(5'd4, 32'd5);
    pulse_start();
    wait_irq("dir_irq");
    bus_rd(5'd30, rd); chk("dir_status", rd, 32'h0001_0001);
    bus_wr(5'd3, 32'd0);
    for (int n = 0; n < 14; n++) begin
      bus_rd(5'd2, rd);
      chk($sformatf("dir_z%0d", n), rd, exp5[n]);
    end
    bus_wr(5'd30, 32'h0001_0001);
    @(negedge clk);
    chk("w1c_int_req", {31'b0, int_req}, 32'd1);
    bus_rd(5'd30, rd); chk("w1c_status", rd, 32'h0001_0000);
    bus_wr(5'd30, 32'h0000_0000);
    bus_rd(5'd30, rd); chk("mask0_status", rd, 32'd0);

    // streamed Z reads, one word per cycle
    bus_wr(5'd3, 32'd5);
    @(negedge clk);
    conf_dbus = 5'd2; read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stream%0d", i), data_out, exp5[5 + i]);
      if (i == 2) read = 1'b0;
    end

    // size clamp and 6-bit field
    bus_wr(5'd4, 32'd40);          bus_rd(5'd4, rd); chk("size_clamp", rd, 32'd32);
    bus_wr(5'd4, 32'hFFFF_FF05);   bus_rd(5'd4, rd); chk("size_field", rd, 32'd5);

    // start while busy is ignored; only one done event
    load_y(7, 1'b1);
    bus_wr(5'd4, 32'd32);
    bus_wr(5'd30, 32'h0001_0001);
    pulse_start();
    repeat (20) @(negedge clk);
    bus_rd(5'd30, rd); chk("busy_status", rd, 32'h0001_0100);
    pulse_start();
    wait_irq("busy_irq");
    check_z(32, "busy");
    bus_wr(5'd30, 32'h0001_0001);
    repeat (700) @(negedge clk);
    bus_rd(5'd30, rd); chk("single_done", rd, 32'h0001_0000);
    chk("single_done_irq", {31'b0, int_req}, 32'd1);

    // randomized runs, including the 0 and full-depth boundaries
    for (int t = 0; t < 7; t++) begin
      sz = (t == 0) ? 0 : (t == 1) ? 32 : (t == 2) ? 1 : int'($urandom_range(2, 31));
      load_y(int'($urandom_range(0, 31)), t[0]);
      run_check(sz, $sformatf("rnd%0d", t));
    end

    // en_s low: writes and start are ignored
    bus_wr(5'd4, 32'd3);
    bus_wr(5'd1, 32'd4);
    bus_wr(5'd30, 32'h0001_0000);
    @(negedge clk); en_s = 1'b0;
    bus_wr(5'd4, 32'd9);
    bus_wr(5'd1, 32'd17);
    bus_wr(5'd30, 32'h00FF_0000);
    pulse_start();
    repeat (5) @(negedge clk);
    en_s = 1'b1;
    bus_rd(5'd4, rd);  chk("en_size", rd, 32'd3);
    bus_rd(5'd1, rd);  chk("en_ptr_y", rd, 32'd4);
    bus_rd(5'd30, rd); chk("en_status", rd, 32'h0001_0000);

    // asynchronous reset in the middle of a run
    bus_wr(5'd4, 32'd20);
    bus_wr(5'd30, 32'h0001_0001);
    pulse_start();
    repeat (30) @(negedge clk);
    #2 rst_a = 1'b0;
    #1 chk("mid_rst_int_req", {31'b0, int_req}, 32'd1);
    chk("mid_rst_data_out", data_out, 32'd0);
    @(negedge clk); rst_a = 1'b1;
    bus_rd(5'd30, rd); chk("mid_rst_status", rd, 32'd0);
    bus_rd(5'd4, rd);  chk("mid_rst_size", rd, 32'd0);
    repeat (600) @(negedge clk);
    bus_rd(5'd30, rd); chk("mid_rst_idle", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
